// File: rtl/seq_right_shifter.sv
// Multi-cycle right shifter/rotator: one registered 2:1 stage per clock, stage k selected by amt[k].
// Latency: result valid SHW cycles after operand acceptance; one op per SHW+2 cycles.
// Backpressure: in_ready only in IDLE; Y/out_valid held in DONE until out_ready.
module seq_right_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    input  logic [SHW-1:0]   SHAMT,
    input  logic [1:0]       MODE,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] K_LAST  = SHW'(SHW - 1);
    localparam logic [SHW:0]   W_WIDTH = (SHW + 1)'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   amt;
    logic [1:0]       mode;
    logic [SHW-1:0]   k;

    logic [SHW:0]     stage_sh;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] stage_res;

    // Stage k moves by 2^k; sh never exceeds WIDTH/2 so the rotate's left part is always in range.
    always_comb begin
        stage_sh  = (SHW + 1)'(1) << k;
        shifted   = acc;
        case (mode)
            2'b00:   shifted = acc >> stage_sh;
            2'b01:   shifted = $signed(acc) >>> stage_sh;
            default: shifted = (acc >> stage_sh) | (acc << (W_WIDTH - stage_sh));
        endcase
        stage_res = amt[k] ? shifted : acc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (k == K_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            amt   <= '0;
            mode  <= 2'b00;
            k     <= '0;
            Y     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc  <= D;
                        amt  <= SHAMT;
                        mode <= MODE;
                        k    <= '0;
                    end
                end
                SHIFT: begin
                    acc <= stage_res;
                    if (k == K_LAST) begin
                        Y <= stage_res;
                        k <= '0;
                    end else begin
                        k <= k + SHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed-vector bench for seq_right_shifter with hand-computed results.
module tb_seq_right_shifter;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] D;
    logic [4:0]  SHAMT;
    logic [1:0]  MODE;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_right_shifter #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .SHAMT     (SHAMT),
        .MODE      (MODE),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Full operation with out_ready high: accept, check latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] md, input logic [31:0] exp);
        in_valid  = 1'b1;
        D         = d;
        SHAMT     = sh;
        MODE      = md;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk({tag, "_vld_early"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_y"}, Y, exp);
        tick();
        chk({tag, "_in_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_y_hold"}, Y, exp);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        D         = '0;
        SHAMT     = '0;
        MODE      = 2'b00;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_y", Y, 32'h0000_0000);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("lsr4",   32'h8000_0000, 5'd4,  2'b00, 32'h0800_0000);
        run_op("asr4",   32'h8000_0000, 5'd4,  2'b01, 32'hF800_0000);
        run_op("asr31",  32'h7FFF_FFF0, 5'd31, 2'b01, 32'h0000_0000);
        run_op("ror1",   32'h0000_0001, 5'd1,  2'b10, 32'h8000_0000);
        run_op("ror16",  32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234);
        run_op("ror31",  32'h0000_0003, 5'd31, 2'b10, 32'h0000_0006);
        run_op("zero_l", 32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF);
        run_op("zero_a", 32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF);
        run_op("zero_r", 32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF);

        // Backpressure with a competing operand held on the input the whole time.
        in_valid  = 1'b1;
        D         = 32'h0000_FF00;
        SHAMT     = 5'd8;
        MODE      = 2'b00;
        out_ready = 1'b0;
        tick();
        D     = 32'hF000_0000;
        SHAMT = 5'd28;
        MODE  = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_y", Y, 32'h0000_00FF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_y", Y, 32'h0000_00FF);
            chk("bp_in_rdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_xfer_vld", {31'd0, out_valid}, 32'd0);
        chk("bp_xfer_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp_xfer_y", Y, 32'h0000_00FF);
        tick();
        in_valid = 1'b0;
        chk("bp_accept_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("bp_second_vld", {31'd0, out_valid}, 32'd1);
        chk("bp_second_y", Y, 32'hFFFF_FFFF);
        tick();
        chk("bp_second_done", {31'd0, in_ready}, 32'd1);

        // Reset two cycles into SHIFT abandons the operation.
        in_valid = 1'b1;
        D        = 32'hAAAA_5555;
        SHAMT    = 5'd3;
        MODE     = 2'b10;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_y", Y, 32'h0000_0000);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        run_op("post_rst", 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_000F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
